// File: rtl/v_alu_seq.sv
// -----------------------------------------------------------------------------
// v_alu_seq : operand sequencer / result collector for the vector ALU.
//
// Takes one vector instruction (two VECTOR_LENGTH-bit sources, opcode, vsew)
// over a valid/ready handshake. It feeds the ALU one VALU_OP_W_MAX-bit slice
// per cycle. Each slice result is captured after the opcode-dependent ALU
// latency, and the assembled destination vector is returned over a
// valid/ready handshake.
//
// Optional feature macro: VALU_SEQ_VL_EN
//   When it is defined, an in_vl port (active element count) is added.
//   Only the slices that cover the active elements are issued, and tail
//   elements are zeroed in out_vd.
//
// Ports:
//   clk, nrst                      clock (rising edge), async active-low reset
//   in_valid / in_ready            instruction handshake
//   in_op_instr, in_vsew           opcode and element-width code
//   in_vs_A, in_vs_B               source vectors
//   in_vl                          active element count (VALU_SEQ_VL_EN only)
//   out_valid / out_ready          result handshake
//   out_vd                         assembled result vector
//   alu_op_instr, alu_vsew         to the ALU control inputs
//   alu_op_A, alu_op_B             to the ALU operand inputs
//   alu_result                     from the ALU result output
//   busy                           high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module v_alu_seq #(
  parameter int VECTOR_LENGTH = 128,
  parameter int VALU_OP_W_MAX = 32,
  parameter int ADDSUB_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_op_instr,
  input  logic [1:0]                    in_vsew,
  input  logic [VECTOR_LENGTH-1:0]      in_vs_A,
  input  logic [VECTOR_LENGTH-1:0]      in_vs_B,
`ifdef VALU_SEQ_VL_EN
  input  logic [$clog2(VECTOR_LENGTH/8+1)-1:0] in_vl,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [VECTOR_LENGTH-1:0]      out_vd,
  output logic [3:0]                    alu_op_instr,
  output logic [1:0]                    alu_vsew,
  output logic [VALU_OP_W_MAX-1:0]      alu_op_A,
  output logic [VALU_OP_W_MAX-1:0]      alu_op_B,
  input  logic [VALU_OP_W_MAX-1:0]      alu_result,
  output logic                          busy
);

  localparam int N_SLICE = VECTOR_LENGTH / VALU_OP_W_MAX;
  localparam int CNT_W   = $clog2(N_SLICE + 1);
  localparam int LAT_W   = (ADDSUB_LAT < 1) ? 1 : $clog2(ADDSUB_LAT + 1);
  localparam int SL_D    = (ADDSUB_LAT < 1) ? 1 : ADDSUB_LAT;

  // v_pkg opcode encodings used for latency selection
  localparam logic [3:0] VALU_VADD = 4'h0;
  localparam logic [3:0] VALU_VSUB = 4'h1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]               state;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         last_idx;
  logic [LAT_W-1:0]         dcnt;
  logic [LAT_W-1:0]         lat_r;
  logic [LAT_W-1:0]         lat_in;
  logic [VECTOR_LENGTH-1:0] vs_a_r;
  logic [VECTOR_LENGTH-1:0] vs_b_r;

  // Capture shift line: one {valid, slice index} entry per ALU latency cycle.
  logic                     vld_p [SL_D];
  logic [CNT_W-1:0]         idx_p [SL_D];
  logic                     cap_vld;
  logic [CNT_W-1:0]         cap_idx;
  logic [VALU_OP_W_MAX-1:0] cap_data;

  function automatic logic [VALU_OP_W_MAX-1:0] slice_of(
    input logic [VECTOR_LENGTH-1:0] v,
    input int unsigned              k
  );
    return v[k*VALU_OP_W_MAX +: VALU_OP_W_MAX];
  endfunction

`ifdef VALU_SEQ_VL_EN
  logic [31:0]      act_r;   // number of active bits (vl * SEW)
  logic [31:0]      act_in;
  logic [31:0]      nsl_in;
  logic [CNT_W-1:0] n_issue_r;

  // Elements are packed from the LSB, so "element index >= vl" is the same
  // as "bit index >= vl*SEW". This masks one slice at that bit boundary.
  function automatic logic [VALU_OP_W_MAX-1:0] tail_mask(
    input int unsigned k,
    input logic [31:0] act_bits
  );
    logic [VALU_OP_W_MAX-1:0] m;
    for (int b = 0; b < VALU_OP_W_MAX; b++)
      m[b] = ((k * VALU_OP_W_MAX + 32'(b)) < act_bits);
    return m;
  endfunction

  always_comb begin
    act_in = 32'(in_vl) << (32'd3 + 32'(in_vsew));
    nsl_in = (act_in + 32'(VALU_OP_W_MAX) - 32'd1) / 32'(VALU_OP_W_MAX);
    if (nsl_in > 32'(N_SLICE))
      nsl_in = 32'(N_SLICE);
  end

  assign last_idx = n_issue_r - 1'b1;
`else
  assign last_idx = CNT_W'(N_SLICE - 1);
`endif

  assign lat_in   = ((in_op_instr == VALU_VADD) || (in_op_instr == VALU_VSUB))
                    ? LAT_W'(ADDSUB_LAT) : '0;
  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  // Operand storage is pure data and carries no reset.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && in_valid) begin
      vs_a_r <= in_vs_A;
      vs_b_r <= in_vs_B;
    end
  end

  // ---- control FSM and ALU issue stage ----
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      dcnt         <= '0;
      lat_r        <= '0;
      out_valid    <= 1'b0;
      alu_op_instr <= '0;
      alu_vsew     <= '0;
      alu_op_A     <= '0;
      alu_op_B     <= '0;
`ifdef VALU_SEQ_VL_EN
      act_r        <= '0;
      n_issue_r    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            lat_r <= lat_in;
            cnt   <= '0;
            dcnt  <= '0;
`ifdef VALU_SEQ_VL_EN
            act_r     <= act_in;
            n_issue_r <= CNT_W'(nsl_in);
            if (nsl_in == 32'd0) begin
              // Nothing active: result is all zero, skip the ALU entirely.
              state     <= S_DONE;
              out_valid <= 1'b1;
            end else begin
              state        <= S_ISSUE;
              alu_op_instr <= in_op_instr;
              alu_vsew     <= in_vsew;
              alu_op_A     <= slice_of(in_vs_A, 32'd0);
              alu_op_B     <= slice_of(in_vs_B, 32'd0);
            end
`else
            state        <= S_ISSUE;
            alu_op_instr <= in_op_instr;
            alu_vsew     <= in_vsew;
            alu_op_A     <= slice_of(in_vs_A, 32'd0);
            alu_op_B     <= slice_of(in_vs_B, 32'd0);
`endif
          end
        end
        S_ISSUE: begin
          if (cnt == last_idx) begin
            if (lat_r != '0) begin
              state <= S_DRAIN;
              dcnt  <= '0;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
            end
          end else begin
            cnt      <= cnt + 1'b1;
            alu_op_A <= slice_of(vs_a_r, 32'(cnt) + 32'd1);
            alu_op_B <= slice_of(vs_b_r, 32'(cnt) + 32'd1);
          end
        end
        S_DRAIN: begin
          // ALU inputs stay on the last slice so its clock enable stays up.
          if (dcnt == LAT_W'(lat_r - 1'b1)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Select the tracking entry that matches the latency of this instruction.
  always_comb begin
    cap_vld = 1'b0;
    cap_idx = '0;
    if (lat_r == '0) begin
      cap_vld = (state == S_ISSUE);
      cap_idx = cnt;
    end else begin
      for (int i = 0; i < SL_D; i++) begin
        if (32'(lat_r) == 32'(i + 1)) begin
          cap_vld = vld_p[i];
          cap_idx = idx_p[i];
        end
      end
    end
  end

`ifdef VALU_SEQ_VL_EN
  assign cap_data = alu_result & tail_mask(32'(cap_idx), act_r);
`else
  assign cap_data = alu_result;
`endif

  // ---- result capture stage ----
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_vd <= '0;
      for (int i = 0; i < SL_D; i++) begin
        vld_p[i] <= 1'b0;
        idx_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= (state == S_ISSUE);
      idx_p[0] <= cnt;
      for (int i = 1; i < SL_D; i++) begin
        vld_p[i] <= vld_p[i-1];
        idx_p[i] <= idx_p[i-1];
      end
`ifdef VALU_SEQ_VL_EN
      // Slices that are never issued must read back as zero.
      if ((state == S_IDLE) && in_valid)
        out_vd <= '0;
`endif
      if (cap_vld)
        out_vd[32'(cap_idx)*VALU_OP_W_MAX +: VALU_OP_W_MAX] <= cap_data;
    end
  end

endmodule
